// File: rtl/full_adder_bit.sv
// One-bit combinational full adder; one stage of the ripple chain in full_adder4.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder4.sv
// Registered ripple-carry adder: {cout4, s} = a + b + cin, plus signed overflow.
// One output register stage; a result captured on edge N is visible right after edge N.
module full_adder4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout4,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             c_msb_in;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             vld_q;

    // Each stage owns its own carry-in/carry-out wires instead of sharing one
    // carry vector, so the chain is a plain forward path with no self-loop.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic ci;
        logic co;

        if (i == 0) begin : g_c0
            assign ci = cin;
        end else begin : g_cn
            assign ci = g_stage[i-1].co;
        end

        full_adder_bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (ci),
            .s    (sum_d[i]),
            .cout (co)
        );
    end

    assign c_msb_in = g_stage[WIDTH-1].ci;
    assign cout_d   = g_stage[WIDTH-1].co;
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf_d    = c_msb_in ^ cout_d;

    // Output register: capture on in_valid, otherwise hold data and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                s_q    <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign s         = s_q;
    assign cout4     = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder4.sv
// Self-checking bench for full_adder4: directed steps, exhaustive sweep and
// random traffic against an integer-arithmetic reference model.
module tb_full_adder4;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] s;
    logic       cout4;
    logic       ovf;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [3:0] m_s;
    logic       m_c;
    logic       m_o;
    logic       m_v;

    full_adder4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout4     (cout4),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got v/o/c/s=%b expected %b", tag, obs, exp);
        end
    endtask

    // Model: plain unsigned and signed integer sums.
    task automatic model_accept(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        int u;
        int sv;
        u   = int'(ma) + int'(mb) + int'(mc);
        sv  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        m_s = u[3:0];
        m_c = (u > 15);
        m_o = (sv > 7) || (sv < -8);
        m_v = 1'b1;
    endtask

    task automatic model_reset();
        m_s = 4'h0; m_c = 1'b0; m_o = 1'b0; m_v = 1'b0;
    endtask

    // Drive on the falling edge, check 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                        input logic sc, input logic sv);
        @(negedge clk);
        a = sa; b = sb; cin = sc; in_valid = sv;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (sv) model_accept(sa, sb, sc);
            else    m_v = 1'b0;
        end
        chk(tag, {out_valid, ovf, cout4, s}, {m_v, m_o, m_c, m_s});
    endtask

    initial begin
        rst_n = 1'b0; a = 4'($urandom); b = 4'($urandom); cin = 1'b0; in_valid = 1'b1;
        model_reset();

        // reset held low across edges with random operands
        repeat (3) begin
            @(negedge clk);
            a = 4'($urandom); b = 4'($urandom); cin = 1'($urandom);
        end
        #1;
        chk("reset_hold", {out_valid, ovf, cout4, s}, 7'b0);

        @(negedge clk);
        rst_n = 1'b1;
        step("first_1p1", 4'b0001, 4'b0001, 1'b0, 1'b1);
        chk("first_1p1_const", {out_valid, ovf, cout4, s}, {1'b1, 1'b0, 1'b0, 4'b0010});

        // carry chain, back to back
        step("3p1",  4'b0011, 4'b0001, 1'b0, 1'b1);
        chk("3p1_const", {out_valid, ovf, cout4, s}, {1'b1, 1'b0, 1'b0, 4'b0100});
        step("1p7",  4'b0001, 4'b0111, 1'b0, 1'b1);
        chk("1p7_const", {out_valid, ovf, cout4, s}, {1'b1, 1'b1, 1'b0, 4'b1000});
        step("8p7",  4'b1000, 4'b0111, 1'b0, 1'b1);
        chk("8p7_const", {out_valid, ovf, cout4, s}, {1'b1, 1'b0, 1'b0, 4'b1111});

        // carry-out and wrap
        step("8pF",  4'b1000, 4'b1111, 1'b0, 1'b1);
        chk("8pF_const", {out_valid, ovf, cout4, s}, {1'b1, 1'b1, 1'b1, 4'b0111});
        step("Fp0c", 4'b1111, 4'b0000, 1'b1, 1'b1);
        chk("Fp0c_const", {out_valid, ovf, cout4, s}, {1'b1, 1'b0, 1'b1, 4'b0000});

        // hold: in_valid low, operands change
        step("hold1", 4'b0101, 4'b0110, 1'b1, 1'b0);
        chk("hold1_const", {out_valid, ovf, cout4, s}, {1'b0, 1'b0, 1'b1, 4'b0000});
        step("hold2", 4'b1110, 4'b1011, 1'b0, 1'b0);

        // async reset between edges during valid traffic
        step("pre_rst", 4'b0110, 4'b0111, 1'b1, 1'b1);
        @(negedge clk);
        a = 4'b1001; b = 4'b1001; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst", {out_valid, ovf, cout4, s}, 7'b0);
        step("rst_low_edge", 4'b1111, 4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 4'b0010, 4'b0011, 1'b0, 1'b1);

        // exhaustive sweep, back to back
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step("exh", v[3:0], v[7:4], v[8], 1'b1);
        end

        // random traffic with random valid
        for (int i = 0; i < 200; i++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
